// File: rtl/aes_pkg.sv
// Shared AES types and constants for the byte-serial / narrow-datapath AES core.
package aes_pkg;

    localparam int unsigned AES_STATE_W = 128;
    localparam int unsigned AES_BYTES   = 16;

    // One 32-bit column; row 0 is the most significant byte.
    typedef logic [31:0] aes_col_t;

    // Full state as four columns. Element 3 is w0 (state[127:96]), element 0 is w3.
    typedef aes_col_t [3:0] aes_state_t;

    // Streaming stage control: collect a state, then emit it.
    typedef enum logic {
        FILL,
        DRAIN
    } fsm_state_e;

endpackage

// File: rtl/inv_shift_rows_comb.sv
// Purely combinational InvShiftRows on a full 128-bit AES state.
// Output column c, row r takes input column (c - r) mod 4, row r.
module inv_shift_rows_comb
    import aes_pkg::*;
(
    input  logic [AES_STATE_W-1:0] state,
    output logic [AES_STATE_W-1:0] shifted
);

    aes_state_t s_in;
    aes_state_t s_out;

    assign s_in    = state;
    assign shifted = s_out;

    // Column c lives at packed element 3-c; row r is bits [31-8r -: 8] of a column.
    for (genvar c = 0; c < 4; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            assign s_out[3-c][31-8*r -: 8] = s_in[3-((c-r+4)%4)][31-8*r -: 8];
        end
    end

endmodule

// File: rtl/inv_shift_row_stream.sv
// Streaming InvShiftRows stage: buffers one AES state arriving as DATA_W-bit beats,
// permutes it and replays it MSB-first on the output stream.
module inv_shift_row_stream
    import aes_pkg::*;
#(
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    input  logic              in_last,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              out_last,
    input  logic              out_ready,
    output logic              frame_err
);

    localparam int unsigned BEATS = AES_STATE_W / DATA_W;
    localparam int unsigned CNT_W = $clog2(BEATS);

    fsm_state_e             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [AES_STATE_W-1:0] in_buf_q, in_buf_d;
    logic [AES_STATE_W-1:0] out_buf_q, out_buf_d;
    logic                   frame_err_q, frame_err_d;

    logic [AES_STATE_W-1:0] in_merged;
    logic [AES_STATE_W-1:0] in_shifted;
    logic [DATA_W-1:0]      out_beats [BEATS];
    logic                   in_fire;
    logic                   out_fire;
    logic                   cnt_at_last;

    // Input buffer with the incoming beat already dropped into slot cnt, so the final
    // beat can be permuted straight into the output buffer on its acceptance edge.
    for (genvar i = 0; i < BEATS; i++) begin : g_slot
        localparam int unsigned Hi = AES_STATE_W - 1 - i * DATA_W;
        assign in_merged[Hi -: DATA_W] = (cnt_q == CNT_W'(i)) ? in_data : in_buf_q[Hi -: DATA_W];
        assign out_beats[i]            = out_buf_q[Hi -: DATA_W];
    end

    inv_shift_rows_comb u_inv_shift_rows (
        .state   (in_merged),
        .shifted (in_shifted)
    );

    assign cnt_at_last = (cnt_q == CNT_W'(BEATS - 1));
    assign in_ready    = (state_q == FILL) && !rst;
    assign in_fire     = in_valid && in_ready;
    assign out_valid   = (state_q == DRAIN);
    assign out_fire    = out_valid && out_ready;
    assign out_last    = out_valid && cnt_at_last;
    assign out_data    = out_valid ? out_beats[cnt_q] : '0;
    assign frame_err   = frame_err_q;

    // Next-state: beat collection, framing check, permuted load and replay.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        in_buf_d    = in_buf_q;
        out_buf_d   = out_buf_q;
        frame_err_d = 1'b0;
        unique case (state_q)
            FILL: begin
                if (in_fire) begin
                    if (in_last != cnt_at_last) begin
                        // Early or missing in_last: drop the partial state and restart.
                        cnt_d       = '0;
                        frame_err_d = 1'b1;
                    end else if (cnt_at_last) begin
                        out_buf_d = in_shifted;
                        cnt_d     = '0;
                        state_d   = DRAIN;
                    end else begin
                        in_buf_d = in_merged;
                        cnt_d    = cnt_q + CNT_W'(1);
                    end
                end
            end
            DRAIN: begin
                if (out_fire) begin
                    if (cnt_at_last) begin
                        cnt_d   = '0;
                        state_d = FILL;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = FILL;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= FILL;
            cnt_q       <= '0;
            in_buf_q    <= '0;
            out_buf_q   <= '0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            in_buf_q    <= in_buf_d;
            out_buf_q   <= out_buf_d;
            frame_err_q <= frame_err_d;
        end
    end

endmodule

// File: tb/tb_inv_shift_row_stream.sv
// Self-checking bench for inv_shift_row_stream with a byte-array reference model.
module tb_inv_shift_row_stream;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned BEATS  = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [DATA_W-1:0] in_data = '0;
    logic              in_valid = 1'b0;
    logic              in_last = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_last;
    logic              out_ready = 1'b0;
    logic              frame_err;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    inv_shift_row_stream #(
        .DATA_W (DATA_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_last  (out_last),
        .out_ready (out_ready),
        .frame_err (frame_err)
    );

    logic [127:0]      basic_state = 128'h00112233_44556677_8899aabb_ccddeeff;
    logic [DATA_W-1:0] exp_basic [8] = '{16'h00dd, 16'haa77, 16'h4411, 16'heebb,
                                         16'h8855, 16'h22ff, 16'hcc99, 16'h6633};

    // Stimulus queue and per-cycle logs
    logic [DATA_W-1:0] tx_data [$];
    logic              tx_last [$];
    logic              lg_ov [$];
    logic              lg_or [$];
    logic              lg_ol [$];
    logic              lg_ir [$];
    logic              lg_fe [$];
    logic [DATA_W-1:0] lg_od [$];
    logic [DATA_W-1:0] rx_data [$];
    logic              rx_last [$];
    int                rx_cyc [$];
    int                acc_cyc [$];

    // Reference: state as 16 bytes, byte index 4*column + row, byte 0 at the MSB.
    function automatic logic [127:0] ref_inv_shift(input logic [127:0] s);
        logic [7:0] b [16];
        logic [7:0] o [16];
        logic [127:0] res;
        for (int i = 0; i < 16; i++) b[i] = s[127-8*i -: 8];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[4*c+r] = b[4*((c-r+4)%4)+r];
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = o[i];
        return res;
    endfunction

    function automatic logic [127:0] ref_fwd_shift(input logic [127:0] s);
        logic [7:0] b [16];
        logic [7:0] o [16];
        logic [127:0] res;
        for (int i = 0; i < 16; i++) b[i] = s[127-8*i -: 8];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[4*c+r] = b[4*((c+r)%4)+r];
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = o[i];
        return res;
    endfunction

    function automatic logic [127:0] rx_state(input int base);
        logic [127:0] s = '0;
        for (int i = 0; i < int'(BEATS); i++)
            if (base + i < rx_data.size()) s[127-DATA_W*i -: DATA_W] = rx_data[base+i];
        return s;
    endfunction

    function automatic logic [127:0] rand_state();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Queue nbeats beats of s; in_last is set on beat last_at (-1 for never).
    task automatic push_frame(input logic [127:0] s, input int nbeats, input int last_at);
        for (int i = 0; i < nbeats; i++) begin
            tx_data.push_back(s[127-DATA_W*i -: DATA_W]);
            tx_last.push_back(i == last_at);
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        tx_data.delete();
        tx_last.delete();
    endtask

    // Drives the tx queue for a fixed number of cycles and logs every cycle.
    // ready_mode: 0 always ready, 1 ready every third cycle, 2 random.
    task automatic run_stream(input int unsigned gap_pct, input int ready_mode, input int ncyc);
        int idx = 0;
        lg_ov.delete(); lg_or.delete(); lg_ol.delete(); lg_ir.delete();
        lg_fe.delete(); lg_od.delete();
        rx_data.delete(); rx_last.delete(); rx_cyc.delete(); acc_cyc.delete();
        for (int cyc = 0; cyc < ncyc; cyc++) begin
            if (idx < tx_data.size() && $urandom_range(99) >= gap_pct) begin
                in_valid = 1'b1;
                in_data  = tx_data[idx];
                in_last  = tx_last[idx];
            end else begin
                in_valid = 1'b0;
                in_data  = '0;
                in_last  = 1'b0;
            end
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (cyc % 3 == 0);
                default: out_ready = 1'($urandom_range(1));
            endcase
            #1;
            lg_ov.push_back(out_valid);
            lg_or.push_back(out_ready);
            lg_ol.push_back(out_last);
            lg_ir.push_back(in_ready);
            lg_fe.push_back(frame_err);
            lg_od.push_back(out_data);
            if (in_valid && in_ready) begin
                acc_cyc.push_back(cyc);
                idx++;
            end
            if (out_valid && out_ready) begin
                rx_data.push_back(out_data);
                rx_last.push_back(out_last);
                rx_cyc.push_back(cyc);
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = '0;
    endtask

    task automatic test_reset();
        @(posedge clk);
        #1;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL rst_in_ready: got %b want 0", in_ready);
        end
        checks++;
        if (out_valid !== 1'b0 || out_last !== 1'b0 || out_data !== '0 || frame_err !== 1'b0) begin
            errors++;
            $display("FAIL rst_outputs: got valid=%b last=%b data=%h ferr=%b want 0/0/0000/0",
                     out_valid, out_last, out_data, frame_err);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL rst_release_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_basic();
        int fe_cnt = 0;
        do_reset();
        push_frame(basic_state, 8, 7);
        run_stream(0, 0, 30);
        checks++;
        if (rx_data.size() != 8) begin
            errors++; $display("FAIL basic_count: got %0d beats want 8", rx_data.size());
        end
        for (int i = 0; i < 8 && i < rx_data.size(); i++) begin
            checks++;
            if (rx_data[i] !== exp_basic[i] || rx_last[i] !== (i == 7)) begin
                errors++;
                $display("FAIL basic_beat%0d: got %h last=%b want %h last=%b",
                         i, rx_data[i], rx_last[i], exp_basic[i], (i == 7));
            end
        end
        if (rx_cyc.size() > 0 && acc_cyc.size() == 8) begin
            checks++;
            if (rx_cyc[0] != acc_cyc[7] + 1) begin
                errors++;
                $display("FAIL basic_latency: first out cycle %0d want %0d", rx_cyc[0], acc_cyc[7] + 1);
            end
        end
        foreach (lg_fe[k]) if (lg_fe[k]) fe_cnt++;
        checks++;
        if (fe_cnt != 0) begin
            errors++; $display("FAIL basic_frame_err: got %0d pulses want 0", fe_cnt);
        end
    endtask

    task automatic test_backpressure();
        int bad_stall = 0;
        int bad_ready = 0;
        do_reset();
        push_frame(basic_state, 8, 7);
        run_stream(0, 1, 80);
        checks++;
        if (rx_data.size() != 8) begin
            errors++; $display("FAIL bp_count: got %0d beats want 8", rx_data.size());
        end
        for (int i = 0; i < 8 && i < rx_data.size(); i++) begin
            checks++;
            if (rx_data[i] !== exp_basic[i] || rx_last[i] !== (i == 7)) begin
                errors++;
                $display("FAIL bp_beat%0d: got %h last=%b want %h last=%b",
                         i, rx_data[i], rx_last[i], exp_basic[i], (i == 7));
            end
        end
        for (int k = 0; k + 1 < lg_ov.size(); k++) begin
            if (lg_ov[k] && !lg_or[k]) begin
                if (!lg_ov[k+1] || lg_od[k+1] !== lg_od[k] || lg_ol[k+1] !== lg_ol[k]) bad_stall++;
            end
        end
        checks++;
        if (bad_stall != 0) begin
            errors++; $display("FAIL bp_stall_stable: got %0d unstable cycles want 0", bad_stall);
        end
        if (acc_cyc.size() == 8 && rx_cyc.size() == 8) begin
            for (int k = acc_cyc[7] + 1; k <= rx_cyc[7]; k++) if (lg_ir[k] !== 1'b0) bad_ready++;
            checks++;
            if (bad_ready != 0 || lg_ir[rx_cyc[7] + 1] !== 1'b1) begin
                errors++;
                $display("FAIL bp_in_ready: got %0d busy-ready cycles, after=%b want 0 and 1",
                         bad_ready, lg_ir[rx_cyc[7] + 1]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] orig [100];
        int bad_timing = 0;
        do_reset();
        for (int s = 0; s < 100; s++) begin
            orig[s] = rand_state();
            push_frame(ref_fwd_shift(orig[s]), 8, 7);
        end
        run_stream(0, 0, 100 * 16 + 20);
        checks++;
        if (rx_data.size() != 800) begin
            errors++; $display("FAIL rt_count: got %0d beats want 800", rx_data.size());
        end
        for (int s = 0; s < 100; s++) begin
            checks++;
            if (rx_state(8 * s) !== orig[s]) begin
                errors++;
                $display("FAIL rt_state%0d: got %h want %h", s, rx_state(8 * s), orig[s]);
            end
        end
        if (rx_cyc.size() == 800) begin
            for (int j = 1; j < 800; j++) begin
                if (j % 8 == 0) begin
                    if (rx_cyc[j] - rx_cyc[j-8] != 16) bad_timing++;
                end else if (rx_cyc[j] != rx_cyc[j-1] + 1) begin
                    bad_timing++;
                end
                if (rx_last[j] !== (j % 8 == 7)) bad_timing++;
            end
            checks++;
            if (bad_timing != 0) begin
                errors++; $display("FAIL rt_timing: got %0d irregular beats want 0", bad_timing);
            end
        end
    endtask

    // nbad beats of junk with in_last at bad_last, then one good frame.
    task automatic test_frame_err(input int nbad, input int bad_last);
        logic [127:0] good = rand_state();
        int fe_cnt = 0;
        do_reset();
        push_frame(rand_state(), nbad, bad_last);
        push_frame(good, 8, 7);
        run_stream(0, 0, 50);
        foreach (lg_fe[k]) if (lg_fe[k]) fe_cnt++;
        checks++;
        if (fe_cnt != 1) begin
            errors++; $display("FAIL ferr%0d_pulses: got %0d want 1", nbad, fe_cnt);
        end
        if (acc_cyc.size() >= nbad) begin
            checks++;
            if (lg_fe[acc_cyc[nbad-1] + 1] !== 1'b1) begin
                errors++;
                $display("FAIL ferr%0d_timing: got %b want 1 after bad beat", nbad,
                         lg_fe[acc_cyc[nbad-1] + 1]);
            end
        end
        checks++;
        if (rx_data.size() != 8 || rx_state(0) !== ref_inv_shift(good)) begin
            errors++;
            $display("FAIL ferr%0d_next_frame: got %0d beats %h want 8 beats %h", nbad,
                     rx_data.size(), rx_state(0), ref_inv_shift(good));
        end
    endtask

    task automatic test_reset_mid_drain();
        int idx = 0;
        int hs = 0;
        int stray = 0;
        do_reset();
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 40 && hs < 3; cyc++) begin
            in_valid = (idx < 8);
            in_data  = (idx < 8) ? basic_state[127-DATA_W*idx -: DATA_W] : '0;
            in_last  = (idx == 7);
            #1;
            if (in_valid && in_ready) idx++;
            if (out_valid && out_ready) hs++;
            @(posedge clk);
            #1;
        end
        checks++;
        if (hs != 3) begin
            errors++; $display("FAIL rmd_setup: got %0d handshakes want 3", hs);
        end
        in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL rmd_in_reset: got valid=%b ready=%b want 0/0", out_valid, in_ready);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL rmd_ready_after: got %b want 1", in_ready);
        end
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 20; cyc++) begin
            #1;
            if (out_valid || frame_err) stray++;
            @(posedge clk);
            #1;
        end
        checks++;
        if (stray != 0) begin
            errors++; $display("FAIL rmd_stray_output: got %0d cycles want 0", stray);
        end
    endtask

    task automatic test_gaps();
        logic [127:0] st [5];
        do_reset();
        push_frame(basic_state, 8, 7);
        run_stream(50, 0, 100);
        checks++;
        if (rx_data.size() != 8 || rx_state(0) !== ref_inv_shift(basic_state)) begin
            errors++;
            $display("FAIL gaps_basic: got %0d beats %h want 8 beats %h", rx_data.size(),
                     rx_state(0), ref_inv_shift(basic_state));
        end
        do_reset();
        for (int s = 0; s < 5; s++) begin
            st[s] = rand_state();
            push_frame(st[s], 8, 7);
        end
        run_stream(30, 2, 400);
        for (int s = 0; s < 5; s++) begin
            checks++;
            if (rx_state(8 * s) !== ref_inv_shift(st[s])) begin
                errors++;
                $display("FAIL gaps_rand%0d: got %h want %h", s, rx_state(8 * s),
                         ref_inv_shift(st[s]));
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_back_to_back();
        test_frame_err(4, 3);
        test_frame_err(8, -1);
        test_reset_mid_drain();
        test_gaps();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
